// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 8-bit LFSR generator and its receive-side checker.
// The tap set lives only here so both ends always agree on the sequence.
package lfsr_checker_pkg;

  localparam int unsigned LFSR_W = 8;

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLocked
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for an 8-bit LFSR stream: hunts for a seed, verifies a run of
// correct predictions, then flywheels while counting mismatches.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              clr_err,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [LFSR_W-1:0] expected
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
  localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] expected_q, expected_d;
  logic [3:0]        match_cnt_q, match_cnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (data_valid) begin
      unique case (state_q)
        StHunt: begin
          // The all-zero state is a fixed point of the LFSR and cannot seed tracking.
          if (data_in != '0) begin
            expected_d  = lfsr8_next(data_in);
            match_cnt_d = '0;
            state_d     = StVerify;
          end
        end
        StVerify: begin
          if (data_in == expected_q) begin
            expected_d  = lfsr8_next(data_in);
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_d == LockCnt) begin
              state_d    = StLocked;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
            end
          end else if (data_in != '0) begin
            expected_d  = lfsr8_next(data_in);
            match_cnt_d = '0;
          end else begin
            state_d = StHunt;
          end
        end
        StLocked: begin
          // Flywheel: received data never reseeds, so isolated errors do not derail tracking.
          expected_d = lfsr8_next(expected_q);
          if (data_in == expected_q) begin
            miss_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_d == LossCnt) begin
              state_d     = StHunt;
              locked_d    = 1'b0;
              match_cnt_d = '0;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (clr_err) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: the driver queues hand-computed outputs per issued cycle,
// a negedge monitor pops and compares them. A second instance with ERR_W=2 checks saturation.
module tb_lfsr_checker;

  logic       clk;
  logic       rst;
  logic       data_valid;
  logic [7:0] data_in;
  logic       clr_err;

  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [7:0]  expected;
  logic        locked_s, err_pulse_s;
  logic [1:0]  err_count_s;
  logic [7:0]  expected_s;

  typedef struct {
    logic        l;
    logic        p;
    logic [15:0] e;
    logic [7:0]  x;
  } exp_t;

  exp_t sb_q[$];
  logic issued;
  logic pend;
  int   n_tests;
  int   n_fail;

  lfsr_checker #(
    .LOCK_COUNT(4),
    .LOSS_COUNT(3),
    .ERR_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .data_in   (data_in),
    .clr_err   (clr_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected)
  );

  lfsr_checker #(
    .LOCK_COUNT(4),
    .LOSS_COUNT(3),
    .ERR_W     (2)
  ) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .data_in   (data_in),
    .clr_err   (clr_err),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s),
    .expected  (expected_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pend <= issued;

  always @(negedge clk) begin
    if (pend) begin
      exp_t        it;
      logic [1:0]  e2;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: output seen with empty scoreboard at %0t", $time);
      end else begin
        it = sb_q.pop_front();
        e2 = (it.e > 16'd3) ? 2'd3 : it.e[1:0];
        if (locked !== it.l) begin
          n_fail++;
          $display("FAIL locked @%0t: got %b want %b", $time, locked, it.l);
        end
        n_tests++;
        if (err_pulse !== it.p) begin
          n_fail++;
          $display("FAIL err_pulse @%0t: got %b want %b", $time, err_pulse, it.p);
        end
        n_tests++;
        if (err_count !== it.e) begin
          n_fail++;
          $display("FAIL err_count @%0t: got %0d want %0d", $time, err_count, it.e);
        end
        n_tests++;
        if (expected !== it.x) begin
          n_fail++;
          $display("FAIL expected @%0t: got %h want %h", $time, expected, it.x);
        end
        n_tests++;
        if (err_count_s !== e2) begin
          n_fail++;
          $display("FAIL err_count_sat @%0t: got %0d want %0d", $time, err_count_s, e2);
        end
        n_tests++;
        if (locked_s !== it.l || expected_s !== it.x || err_pulse_s !== it.p) begin
          n_fail++;
          $display("FAIL sat_inst_fsm @%0t: got l=%b p=%b x=%h want l=%b p=%b x=%h", $time,
                   locked_s, err_pulse_s, expected_s, it.l, it.p, it.x);
        end
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after its sampling edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic c,
                      input logic l, input logic p, input logic [15:0] e, input logic [7:0] x);
    exp_t it;
    @(posedge clk);
    #1;
    rst        = r;
    data_valid = v;
    data_in    = d;
    clr_err    = c;
    issued     = 1'b1;
    it.l = l;
    it.p = p;
    it.e = e;
    it.x = x;
    sb_q.push_back(it);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    issued     = 1'b0;
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    clr_err    = 1'b0;
    pend       = 1'b0;

    // Reset state, then acquire lock on 01,02,04,08,11.
    step(1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    step(0, 1, 8'h01, 0, 0, 0, 0, 8'h02);
    step(0, 1, 8'h02, 0, 0, 0, 0, 8'h04);
    step(0, 1, 8'h04, 0, 0, 0, 0, 8'h08);
    step(0, 1, 8'h08, 0, 0, 0, 0, 8'h11);
    step(0, 1, 8'h11, 0, 1, 0, 0, 8'h23);
    // Isolated error while locked; the flywheel keeps tracking.
    step(0, 1, 8'h55, 0, 1, 1, 1, 8'h47);
    step(0, 1, 8'h47, 0, 1, 0, 1, 8'h8E);
    step(0, 1, 8'h8E, 0, 1, 0, 1, 8'h1C);
    // Invalid cycles with garbage data change nothing.
    step(0, 0, 8'hAA, 0, 1, 0, 1, 8'h1C);
    step(0, 0, 8'h1C, 0, 1, 0, 1, 8'h1C);
    step(0, 0, 8'h00, 0, 1, 0, 1, 8'h1C);
    step(0, 1, 8'h1C, 0, 1, 0, 1, 8'h38);
    // clr_err beats the increment but the pulse still fires.
    step(0, 1, 8'h00, 1, 1, 1, 0, 8'h71);
    step(0, 1, 8'h71, 0, 1, 0, 0, 8'hE2);
    // Three consecutive misses lose lock; the third is still counted.
    step(0, 1, 8'h00, 0, 1, 1, 1, 8'hC4);
    step(0, 1, 8'hFF, 0, 1, 1, 2, 8'h89);
    step(0, 1, 8'h33, 0, 0, 1, 3, 8'h12);
    // Restart VERIFY, reseed, fall back to HUNT on zero, ignore zeros in HUNT.
    step(0, 1, 8'h05, 0, 0, 0, 3, 8'h0A);
    step(0, 1, 8'h07, 0, 0, 0, 3, 8'h0E);
    step(0, 1, 8'h00, 0, 0, 0, 3, 8'h0E);
    step(0, 1, 8'h00, 0, 0, 0, 3, 8'h0E);
    step(0, 1, 8'h00, 0, 0, 0, 3, 8'h0E);
    step(0, 1, 8'h01, 0, 0, 0, 3, 8'h02);
    step(0, 1, 8'h05, 0, 0, 0, 3, 8'h0A);
    // Reset mid-VERIFY with valid data present.
    step(1, 1, 8'h0A, 0, 0, 0, 0, 8'h00);
    // Relock, then five isolated errors: wide counter reaches 5, narrow one sticks at 3.
    step(0, 1, 8'h01, 0, 0, 0, 0, 8'h02);
    step(0, 1, 8'h02, 0, 0, 0, 0, 8'h04);
    step(0, 1, 8'h04, 0, 0, 0, 0, 8'h08);
    step(0, 1, 8'h08, 0, 0, 0, 0, 8'h11);
    step(0, 1, 8'h11, 0, 1, 0, 0, 8'h23);
    step(0, 1, 8'h00, 0, 1, 1, 1, 8'h47);
    step(0, 1, 8'h47, 0, 1, 0, 1, 8'h8E);
    step(0, 1, 8'h00, 0, 1, 1, 2, 8'h1C);
    step(0, 1, 8'h1C, 0, 1, 0, 2, 8'h38);
    step(0, 1, 8'h00, 0, 1, 1, 3, 8'h71);
    step(0, 1, 8'h71, 0, 1, 0, 3, 8'hE2);
    step(0, 1, 8'h00, 0, 1, 1, 4, 8'hC4);
    step(0, 1, 8'hC4, 0, 1, 0, 4, 8'h89);
    step(0, 1, 8'h00, 0, 1, 1, 5, 8'h12);
    step(0, 1, 8'h12, 0, 1, 0, 5, 8'h25);

    @(posedge clk);
    #1;
    issued     = 1'b0;
    data_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
